// File: rtl/axis_sample_delay_pkg.sv
// Shared definitions for the AXI-Stream sample delay: ring depth, length clamp
// and the output-select encoding carried alongside the ring read.
package axis_sample_delay_pkg;

    // Source of each registered output beat.
    typedef enum logic [1:0] {
        SEL_ZERO   = 2'd0,
        SEL_RAM    = 2'd1,
        SEL_BYPASS = 2'd2
    } out_sel_e;

    // Ring depth in beats for a given address width.
    function automatic int unsigned depth_of(input int unsigned len_log2);
        return 32'd1 << len_log2;
    endfunction

    // Clamp a requested delay to the largest delay the ring can hold (DEPTH-1).
    function automatic int unsigned clamp_len(input int unsigned len_req,
                                              input int unsigned len_log2);
        int unsigned max_len;
        max_len = depth_of(len_log2) - 32'd1;
        return (len_req > max_len) ? max_len : len_req;
    endfunction

endpackage

// File: rtl/delay_ring_ram.sv
// Simple dual-port ring storage: one write port and one synchronous read port
// with read enable, written so that it maps onto block RAM.
module delay_ring_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Write port, plus a read register that only updates on read enable so
    // the data is held while the downstream consumer stalls.
    // NOTE: the storage array and its read register have no reset; resetting
    // them would prevent block-RAM inference, and every location is written
    // before the control logic ever selects it for output.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_sample_delay.sv
// Multi-channel AXI-Stream sample delay with a run-time programmable length,
// a registered single-stage output with backpressure, and length changes that
// take effect only between packets (each change re-primes the zero prefix).
module axis_sample_delay
    import axis_sample_delay_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int NCHAN        = 2,
    parameter int MAX_LEN_LOG2 = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic [MAX_LEN_LOG2:0]    len,
    input  logic [NCHAN*WIDTH-1:0]   i_tdata,
    input  logic                     i_tlast,
    input  logic                     i_tvalid,
    output logic                     i_tready,
    output logic [NCHAN*WIDTH-1:0]   o_tdata,
    output logic                     o_tlast,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic                     primed
);

    localparam int          DW    = NCHAN * WIDTH;
    localparam int          AW    = MAX_LEN_LOG2;
    localparam int unsigned DEPTH = depth_of(AW);

    // Control state
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_fill;
    logic [AW-1:0] r_len;
    logic          r_in_pkt;

    // Output stage
    logic          r_out_valid;
    logic          r_out_last;
    out_sel_e      r_sel;
    logic [DW-1:0] r_byp_data;

    // Combinational helpers
    logic [AW-1:0] w_len_clamped;
    logic          w_len_load;
    logic [AW-1:0] w_len_eff;
    logic [AW-1:0] w_fill_eff;
    logic [AW-1:0] w_fill_nxt;
    logic [AW-1:0] w_rd_addr;
    logic          w_accept;
    logic          w_ram_en;
    out_sel_e      w_sel;
    logic [DW-1:0] w_ram_rdata;

    assign w_len_clamped = AW'(clamp_len(32'(len), 32'(MAX_LEN_LOG2)));
    assign i_tready      = ~r_out_valid | o_tready;
    assign w_accept      = i_tvalid & i_tready;
    assign w_ram_en      = w_accept & ~clear;
    assign primed        = (r_fill == r_len);

    // Resolve the length/fill seen by this cycle's beat (a pending length load
    // applies to a beat accepted in the same cycle) and pick its output source.
    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        w_len_load = 1'b0;
        w_len_eff  = r_len;
        w_fill_eff = r_fill;
        w_fill_nxt = r_fill;
        w_rd_addr  = r_wr_ptr;
        w_sel      = SEL_RAM;

        if (!r_in_pkt && (w_len_clamped != r_len)) begin
            w_len_load = 1'b1;
            w_len_eff  = w_len_clamped;
            w_fill_eff = '0;
        end

        w_rd_addr = r_wr_ptr - w_len_eff;

        if (w_fill_eff < w_len_eff) begin
            w_fill_nxt = w_fill_eff + AW'(1);
        end else begin
            w_fill_nxt = w_fill_eff;
        end

        if (w_len_eff == '0) begin
            w_sel = SEL_BYPASS;
        end else if (w_fill_eff < w_len_eff) begin
            w_sel = SEL_ZERO;
        end else begin
            w_sel = SEL_RAM;
        end
    end

    // Pointer, fill level, effective length and packet tracking.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_len    <= '0;
            r_in_pkt <= 1'b0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_len    <= w_len_clamped;
            r_in_pkt <= 1'b0;
        end else begin
            if (w_len_load) begin
                r_len <= w_len_clamped;
            end
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_fill   <= w_fill_nxt;
                r_in_pkt <= ~i_tlast;
            end else if (w_len_load) begin
                r_fill <= '0;
            end
        end
    end

    // Registered output stage: loads on accept, empties when taken without refill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_sel       <= SEL_ZERO;
            r_byp_data  <= '0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_last  <= i_tlast;
            r_sel       <= w_sel;
            r_byp_data  <= i_tdata;
        end else if (o_tready) begin
            r_out_valid <= 1'b0;
        end
    end

    delay_ring_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ring (
        .clk     (clk),
        .i_we    (w_ram_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_tdata),
        .i_re    (w_ram_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_rdata)
    );

    // Output mux after the RAM read register, steered by the registered select.
    always_comb begin
        o_tdata = '0;
        unique case (r_sel)
            SEL_RAM:    o_tdata = w_ram_rdata;
            SEL_BYPASS: o_tdata = r_byp_data;
            default:    o_tdata = '0;
        endcase
    end

    assign o_tvalid = r_out_valid;
    assign o_tlast  = r_out_last;

endmodule

// File: tb/tb_axis_sample_delay.sv
// Scoreboard bench for axis_sample_delay: the driver pushes the expected beat
// for every accepted input, and an independent monitor pops and compares on
// every output handshake.
module tb_axis_sample_delay;

    localparam int WIDTH        = 16;
    localparam int NCHAN        = 2;
    localparam int MAX_LEN_LOG2 = 10;
    localparam int DW           = NCHAN * WIDTH;
    localparam int DEPTH_M1     = (1 << MAX_LEN_LOG2) - 1;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  clear;
    logic [MAX_LEN_LOG2:0] len;
    logic [DW-1:0]         i_tdata;
    logic                  i_tlast;
    logic                  i_tvalid;
    logic                  i_tready;
    logic [DW-1:0]         o_tdata;
    logic                  o_tlast;
    logic                  o_tvalid;
    logic                  o_tready = 1'b1;
    logic                  primed;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rand_ready = 1'b0;

    always #5 clk = ~clk;

    axis_sample_delay #(
        .WIDTH        (WIDTH),
        .NCHAN        (NCHAN),
        .MAX_LEN_LOG2 (MAX_LEN_LOG2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .len      (len),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .primed   (primed)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] both(input int v);
        return {16'(v), 16'(v)};
    endfunction

    function automatic logic [DW-1:0] pat(input int k);
        return {16'(k * 3 + 7), 16'(~k)};
    endfunction

    // Downstream ready: always ready, or a fair coin per cycle.
    initial begin
        forever begin
            @(negedge clk);
            o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare each output handshake against the scoreboard and check
    // that a stalled beat holds its data.
    initial begin
        exp_t          e;
        logic          hold_valid;
        logic [DW-1:0] held_data;
        logic          held_last;
        hold_valid = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                hold_valid = 1'b0;
                continue;
            end
            if (o_tvalid && hold_valid) begin
                check("stall_data_stable", 64'(o_tdata), 64'(held_data));
                check("stall_last_stable", 64'(o_tlast), 64'(held_last));
            end
            if (o_tvalid && o_tready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %h with empty scoreboard, required no beat", o_tdata);
                end else begin
                    e = sb_q.pop_front();
                    check("out_tdata", 64'(o_tdata), 64'(e.data));
                    check("out_tlast", 64'(o_tlast), 64'(e.last));
                end
                hold_valid = 1'b0;
            end else if (o_tvalid) begin
                hold_valid = 1'b1;
                held_data  = o_tdata;
                held_last  = o_tlast;
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    // Offer one beat until accepted (bounded), then record its expected output.
    task automatic send_beat(input logic [DW-1:0] d, input logic lst,
                             input logic [DW-1:0] ed, input logic el);
        bit   acc;
        int   guard;
        exp_t e;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            i_tvalid = 1'b1;
            i_tdata  = d;
            i_tlast  = lst;
            #1;
            acc = i_tready;
            @(posedge clk);
            guard++;
        end
        if (acc) begin
            e.data = ed;
            e.last = el;
            sb_q.push_back(e);
        end else begin
            n_checks++;
            $display("FAIL send_timeout: i_tready stayed %0b, required 1", i_tready);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_tvalid = 1'b0;
            i_tlast  = 1'b0;
        end
    endtask

    // Wait (bounded) until every expected beat has been seen and output is empty.
    task automatic drain();
        int guard;
        @(negedge clk);
        i_tvalid   = 1'b0;
        i_tlast    = 1'b0;
        rand_ready = 1'b0;
        guard      = 0;
        while ((sb_q.size() != 0 || o_tvalid) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb_q.size());
        end
    endtask

    task automatic do_clear(input logic [MAX_LEN_LOG2:0] l);
        @(negedge clk);
        len      = l;
        clear    = 1'b1;
        i_tvalid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int t1_exp[8];
        int t4a_exp[6];
        int t4b_exp[8];
        t1_exp  = '{0, 0, 0, 1, 2, 3, 4, 5};
        t4a_exp = '{0, 0, 0, 11, 12, 13};
        t4b_exp = '{0, 0, 0, 0, 0, 21, 22, 23};

        reset_n  = 1'b0;
        clear    = 1'b0;
        len      = '0;
        i_tvalid = 1'b0;
        i_tdata  = '0;
        i_tlast  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_tvalid", 64'(o_tvalid), 64'(0));
        check("rst_o_tdata",  64'(o_tdata),  64'(0));
        check("rst_o_tlast",  64'(o_tlast),  64'(0));
        check("rst_primed",   64'(primed),   64'(1));
        check("rst_i_tready", 64'(i_tready), 64'(1));
        @(negedge clk);
        reset_n = 1'b1;

        // len=3, values 1..8, tlast on beat 8
        do_clear(11'd3);
        check("t1_primed_after_clear", 64'(primed), 64'(0));
        for (int k = 1; k <= 8; k++) begin
            send_beat(both(k), k == 8, both(t1_exp[k-1]), k == 8);
            #1;
            check("t1_primed", 64'(primed), 64'(k >= 3));
        end
        drain();

        // len=0 bypass
        do_clear(11'd0);
        check("t2_primed_after_clear", 64'(primed), 64'(1));
        for (int k = 0; k < 8; k++) begin
            send_beat(both(16'h100 + k), k == 7, both(16'h100 + k), k == 7);
            #1;
            check("t2_primed", 64'(primed), 64'(1));
            if (k == 3) idle(2);
        end
        drain();

        // len=5 with random downstream ready and input gaps
        do_clear(11'd5);
        rand_ready = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            send_beat(pat(k), (k % 16) == 15, (k < 5) ? '0 : pat(k - 5), (k % 16) == 15);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        // len 3 -> 5 requested mid-packet; next packet back-to-back
        do_clear(11'd3);
        for (int k = 0; k < 6; k++) begin
            send_beat(both(11 + k), k == 5, both(t4a_exp[k]), k == 5);
            if (k == 1) len = 11'd5;
            if (k == 3) begin
                #1;
                check("t4_primed_len3_kept", 64'(primed), 64'(1));
            end
        end
        for (int k = 0; k < 8; k++) begin
            send_beat(both(21 + k), k == 7, both(t4b_exp[k]), k == 7);
            #1;
            if (k == 0) check("t4_reprime", 64'(primed), 64'(0));
            if (k == 4) check("t4_primed_len5", 64'(primed), 64'(1));
        end
        drain();

        // len = DEPTH + 7 clamps to DEPTH-1; pointer wraps several times
        do_clear(11'(1024 + 7));
        for (int k = 0; k < 3000; k++) begin
            send_beat(pat(k + 50), (k % 64) == 63,
                      (k < DEPTH_M1) ? '0 : pat(k - DEPTH_M1 + 50), (k % 64) == 63);
        end
        #1;
        check("t5_primed", 64'(primed), 64'(1));
        drain();

        // Reset mid-stream at len=4
        do_clear(11'd4);
        for (int k = 0; k < 10; k++) begin
            send_beat(pat(k + 9000), 1'b0, (k < 4) ? '0 : pat(k - 4 + 9000), 1'b0);
        end
        #1;
        check("t6_valid_before_reset", 64'(o_tvalid), 64'(1));
        @(negedge clk);
        reset_n  = 1'b0;
        i_tvalid = 1'b0;
        #1;
        check("t6_rst_o_tvalid", 64'(o_tvalid), 64'(0));
        check("t6_rst_o_tdata",  64'(o_tdata),  64'(0));
        check("t6_rst_primed",   64'(primed),   64'(1));
        sb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        #1;
        check("t6_len_reloaded", 64'(primed), 64'(0));
        for (int k = 0; k < 8; k++) begin
            send_beat(pat(k + 7000), k == 7, (k < 4) ? '0 : pat(k - 4 + 7000), k == 7);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
